// File: rtl/heart_wave_gen.sv
// heart_wave_gen: synthetic ECG-like sample source.
// Each beat is a P-Q-R-S-T complex followed by a baseline run. A prescaler
// sets the sample rate, and the beat period and R amplitude are latched at
// every beat start. A beat strobe and a beat counter give ground truth for
// a downstream peak detector.
module heart_wave_gen #(
    parameter int DIV_W   = 8,
    parameter int PER_W   = 8,
    parameter int MIN_PER = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [PER_W-1:0] period,
    input  logic             amp_hi,
    output logic [2:0]       sample,
    output logic             sample_valid,
    output logic             beat,
    output logic [7:0]       beat_count
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_RUN    = 1'b1;
    localparam logic [PER_W-1:0] MIN_PER_Q = PER_W'(MIN_PER);
    localparam logic [PER_W-1:0] R_IDX     = PER_W'(3);

    logic [DIV_W-1:0] r_presc;
    logic [0:0]       r_state;
    logic [PER_W-1:0] r_idx;
    logic [PER_W-1:0] r_per_q;
    logic             r_amp_q;
    logic [2:0]       r_sample;
    logic             r_valid;
    logic             r_beat;
    logic [7:0]       r_count;

    logic             w_tick;
    logic             w_beat_start;
    logic [PER_W-1:0] w_per_clamped;
    logic [PER_W-1:0] w_per_eff;
    logic             w_amp_eff;
    logic [PER_W-1:0] w_idx_next;

    // Waveform shape as a function of the position inside the beat.
    function automatic logic [2:0] f_wave(input logic [PER_W-1:0] idx,
                                          input logic             amp);
        logic [2:0] v;
        if (idx < PER_W'(2)) begin
            v = 3'd2;
        end else if (idx == PER_W'(2)) begin
            v = 3'd0;
        end else if (idx == PER_W'(3)) begin
            v = amp ? 3'd7 : 3'd5;
        end else if (idx == PER_W'(4)) begin
            v = 3'd0;
        end else if (idx < PER_W'(8)) begin
            v = 3'd3;
        end else begin
            v = 3'd1;
        end
        return v;
    endfunction

    // Tick decode, period clamping and next-index calculation.
    always_comb begin
        w_tick        = en && (r_presc == div);
        w_beat_start  = w_tick && ((r_state == ST_IDLE) || (r_idx == '0));
        if (period < MIN_PER_Q) begin
            w_per_clamped = MIN_PER_Q;
        end else begin
            w_per_clamped = period;
        end
        // The freshly latched values apply to the beat that starts on this tick.
        if (w_beat_start) begin
            w_per_eff = w_per_clamped;
            w_amp_eff = amp_hi;
        end else begin
            w_per_eff = r_per_q;
            w_amp_eff = r_amp_q;
        end
        if (r_idx == (w_per_eff - PER_W'(1))) begin
            w_idx_next = '0;
        end else begin
            w_idx_next = r_idx + PER_W'(1);
        end
    end

    // Prescaler: counts enabled clocks; a lowered div lets it run to all-ones and wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (en) begin
            if (w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + DIV_W'(1);
            end
        end
    end

    // Beat sequencing: state, sample index and per-beat latched settings.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_per_q <= MIN_PER_Q;
            r_amp_q <= 1'b1;
        end else if (w_tick) begin
            r_state <= ST_RUN;
            r_idx   <= w_idx_next;
            if (w_beat_start) begin
                r_per_q <= w_per_clamped;
                r_amp_q <= amp_hi;
            end
        end
    end

    // Registered outputs: sample value, strobes and beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample <= 3'd1;
            r_valid  <= 1'b0;
            r_beat   <= 1'b0;
            r_count  <= 8'd0;
        end else begin
            r_valid <= w_tick;
            r_beat  <= w_tick && (r_idx == R_IDX);
            if (w_tick) begin
                r_sample <= f_wave(r_idx, w_amp_eff);
                if (r_idx == R_IDX) begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign beat         = r_beat;
    assign beat_count   = r_count;

endmodule

// File: tb/tb_heart_wave_gen.sv
// Self-checking bench for heart_wave_gen. A queue-based reference model
// expands each beat into its list of samples when the beat starts and pops
// one entry per prescaler tick.
module tb_heart_wave_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       amp_hi;
    logic [7:0] div;
    logic [7:0] period;
    logic [2:0] sample;
    logic       sample_valid;
    logic       beat;
    logic [7:0] beat_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_presc;
    int         q_samp[$];
    bit         q_r[$];
    logic [2:0] m_sample;
    logic       m_valid;
    logic       m_beat;
    logic [7:0] m_count;

    heart_wave_gen dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .div          (div),
        .period       (period),
        .amp_hi       (amp_hi),
        .sample       (sample),
        .sample_valid (sample_valid),
        .beat         (beat),
        .beat_count   (beat_count)
    );

    always #5 clk = ~clk;

    function automatic void push_beat(int p, bit amp);
        for (int k = 0; k < p; k++) begin
            int v;
            if (k < 2)       v = 2;
            else if (k == 2) v = 0;
            else if (k == 3) v = amp ? 7 : 5;
            else if (k == 4) v = 0;
            else if (k < 8)  v = 3;
            else             v = 1;
            q_samp.push_back(v);
            q_r.push_back(k == 3);
        end
    endfunction

    function automatic void model_reset();
        m_presc = 0;
        q_samp.delete();
        q_r.delete();
        m_sample = 3'd1;
        m_valid  = 1'b0;
        m_beat   = 1'b0;
        m_count  = 8'd0;
    endfunction

    function automatic void model_edge();
        bit t;
        int p;
        t = 1'b0;
        if (reset) return;
        if (en) begin
            if (m_presc == int'(div)) begin
                t = 1'b1;
                m_presc = 0;
            end else begin
                m_presc = (m_presc + 1) % 256;
            end
        end
        m_valid = t;
        m_beat  = 1'b0;
        if (t) begin
            if (q_samp.size() == 0) begin
                p = int'(period);
                if (p < 9) p = 9;
                push_beat(p, amp_hi);
            end
            m_sample = 3'(q_samp.pop_front());
            if (q_r.pop_front()) begin
                m_beat  = 1'b1;
                m_count = m_count + 8'd1;
            end
        end
    endfunction

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; div = 8'd0; period = 8'd10; amp_hi = 1'b1;
        model_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({sample_valid, beat, sample, beat_count} !== {1'b0, 1'b0, 3'd1, 8'd0}) begin
            errors++;
            $display("FAIL reset_values got %h exp %h", {sample_valid, beat, sample, beat_count}, {1'b0, 1'b0, 3'd1, 8'd0});
        end
        clk_step();
        clk_step();
    endtask

    task automatic test_basic();
        int exp10[10] = '{2, 2, 0, 7, 0, 3, 3, 3, 1, 1};
        hold_reset();
        en = 1'b1; div = 8'd0; period = 8'd10; amp_hi = 1'b1;
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk_step();
            checks++;
            if ({sample_valid, beat, sample, beat_count} !== {m_valid, m_beat, m_sample, m_count}) begin
                errors++;
                $display("FAIL basic_model i=%0d got %h exp %h", i, {sample_valid, beat, sample, beat_count}, {m_valid, m_beat, m_sample, m_count});
            end
            checks++;
            if ({sample_valid, beat, sample} !== {1'b1, (i % 10) == 3, 3'(exp10[i % 10])}) begin
                errors++;
                $display("FAIL basic_seq i=%0d got v=%b b=%b s=%0d exp s=%0d", i, sample_valid, beat, sample, exp10[i % 10]);
            end
        end
        checks++;
        if (beat_count !== 8'd2) begin
            errors++;
            $display("FAIL basic_count got %0d exp 2", beat_count);
        end
    endtask

    task automatic test_div3();
        int nvalid = 0;
        int ones = 0;
        int gap = 0;
        hold_reset();
        en = 1'b0; div = 8'd3; period = 8'd12; amp_hi = 1'b0;
        clk_step();
        reset = 1'b0;
        clk_step();
        clk_step();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL div3_idle got v=%b exp 0", sample_valid);
        end
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            clk_step();
            checks++;
            if (sample_valid !== (i == 4)) begin
                errors++;
                $display("FAIL div3_latency clk=%0d got v=%b exp %b", i, sample_valid, i == 4);
            end
        end
        nvalid = 1;
        if (sample == 3'd1) ones++;
        for (int i = 0; i < 100 && nvalid < 12; i++) begin
            clk_step();
            gap++;
            checks++;
            if ({sample_valid, beat, sample, beat_count} !== {m_valid, m_beat, m_sample, m_count}) begin
                errors++;
                $display("FAIL div3_model got %h exp %h", {sample_valid, beat, sample, beat_count}, {m_valid, m_beat, m_sample, m_count});
            end
            if (sample_valid) begin
                nvalid++;
                checks++;
                if (gap != 4) begin
                    errors++;
                    $display("FAIL div3_gap got %0d exp 4", gap);
                end
                gap = 0;
                if (sample == 3'd1) ones++;
                if (beat) begin
                    checks++;
                    if (sample !== 3'd5) begin
                        errors++;
                        $display("FAIL div3_rpeak got %0d exp 5", sample);
                    end
                end
            end
        end
        checks++;
        if (nvalid != 12 || ones != 4) begin
            errors++;
            $display("FAIL div3_baseline got valids=%0d ones=%0d exp valids=12 ones=4", nvalid, ones);
        end
    endtask

    task automatic test_clamp();
        int exp9[9] = '{2, 2, 0, 7, 0, 3, 3, 3, 1};
        for (int pass = 0; pass < 2; pass++) begin
            hold_reset();
            en = 1'b1; div = 8'd0; amp_hi = 1'b1;
            period = (pass == 0) ? 8'd4 : 8'd0;
            clk_step();
            reset = 1'b0;
            for (int i = 0; i < 18; i++) begin
                clk_step();
                checks++;
                if ({sample_valid, beat, sample, beat_count} !== {m_valid, m_beat, m_sample, m_count}) begin
                    errors++;
                    $display("FAIL clamp_model p=%0d got %h exp %h", period, {sample_valid, beat, sample, beat_count}, {m_valid, m_beat, m_sample, m_count});
                end
                checks++;
                if (sample !== 3'(exp9[i % 9])) begin
                    errors++;
                    $display("FAIL clamp_seq p=%0d i=%0d got %0d exp %0d", period, i, sample, exp9[i % 9]);
                end
            end
        end
    endtask

    task automatic test_change_mid();
        hold_reset();
        en = 1'b1; div = 8'd0; period = 8'd10; amp_hi = 1'b1;
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            clk_step();
            if (i == 3) begin
                checks++;
                if ({beat, sample} !== {1'b1, 3'd7}) begin
                    errors++;
                    $display("FAIL change_first_r got b=%b s=%0d exp b=1 s=7", beat, sample);
                end
            end
        end
        period = 8'd20; amp_hi = 1'b0;
        for (int i = 0; i < 30; i++) begin
            clk_step();
            checks++;
            if ({sample_valid, beat, sample, beat_count} !== {m_valid, m_beat, m_sample, m_count}) begin
                errors++;
                $display("FAIL change_model i=%0d got %h exp %h", i, {sample_valid, beat, sample, beat_count}, {m_valid, m_beat, m_sample, m_count});
            end
            checks++;
            if (beat !== (i == 7 || i == 27)) begin
                errors++;
                $display("FAIL change_beat_pos i=%0d got %b exp %b", i, beat, i == 7 || i == 27);
            end
            if (i == 7) begin
                checks++;
                if (sample !== 3'd5) begin
                    errors++;
                    $display("FAIL change_new_r got %0d exp 5", sample);
                end
            end
        end
    endtask

    task automatic test_en_gap();
        int nvalid = 0;
        hold_reset();
        en = 1'b1; div = 8'd1; period = 8'd10; amp_hi = 1'b1;
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 20 && nvalid < 3; i++) begin
            clk_step();
            if (sample_valid) nvalid++;
        end
        checks++;
        if (nvalid != 3 || sample !== 3'd0) begin
            errors++;
            $display("FAIL gap_third got valids=%0d s=%0d exp valids=3 s=0", nvalid, sample);
        end
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            clk_step();
            checks++;
            if ({sample_valid, beat, sample} !== {1'b0, 1'b0, 3'd0}) begin
                errors++;
                $display("FAIL gap_hold i=%0d got v=%b b=%b s=%0d exp v=0 b=0 s=0", i, sample_valid, beat, sample);
            end
        end
        en = 1'b1;
        clk_step();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_resume_early got v=%b exp 0", sample_valid);
        end
        clk_step();
        checks++;
        if ({sample_valid, beat, sample} !== {1'b1, 1'b1, 3'd7}) begin
            errors++;
            $display("FAIL gap_resume got v=%b b=%b s=%0d exp v=1 b=1 s=7", sample_valid, beat, sample);
        end
    endtask

    task automatic test_random();
        hold_reset();
        en = 1'b1; div = 8'd0; period = 8'd10; amp_hi = 1'b1;
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            clk_step();
            checks++;
            if ({sample_valid, beat, sample, beat_count} !== {m_valid, m_beat, m_sample, m_count}) begin
                errors++;
                $display("FAIL random_model i=%0d got %h exp %h", i, {sample_valid, beat, sample, beat_count}, {m_valid, m_beat, m_sample, m_count});
            end
            en     = ($urandom_range(0, 7) != 0);
            period = 8'($urandom_range(0, 24));
            amp_hi = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) div = 8'($urandom_range(0, 3));
        end
    endtask

    task automatic test_wrap();
        int nbeats = 0;
        hold_reset();
        en = 1'b1; div = 8'd0; period = 8'd9; amp_hi = 1'b1;
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) clk_step();
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({sample_valid, beat, sample, beat_count} !== {1'b0, 1'b0, 3'd1, 8'd0}) begin
            errors++;
            $display("FAIL wrap_async_reset got %h exp %h", {sample_valid, beat, sample, beat_count}, {1'b0, 1'b0, 3'd1, 8'd0});
        end
        clk_step();
        reset = 1'b0;
        clk_step();
        checks++;
        if ({sample_valid, sample} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL wrap_restart got v=%b s=%0d exp v=1 s=2", sample_valid, sample);
        end
        for (int i = 0; i < 3000 && nbeats < 256; i++) begin
            clk_step();
            checks++;
            if ({sample_valid, beat, sample, beat_count} !== {m_valid, m_beat, m_sample, m_count}) begin
                errors++;
                $display("FAIL wrap_model i=%0d got %h exp %h", i, {sample_valid, beat, sample, beat_count}, {m_valid, m_beat, m_sample, m_count});
            end
            if (beat) nbeats++;
        end
        checks++;
        if (nbeats != 256 || beat_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_count got beats=%0d count=%0d exp beats=256 count=0", nbeats, beat_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div3();
        test_clamp();
        test_change_mid();
        test_en_gap();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/heart_wave_gen.md
Name: heart_wave_gen

Overview:
- Synthetic heartbeat source.
- Produces the 3-bit sample stream that the threshold filter / peak detector consumes.
- Each beat is a P-Q-R-S-T complex followed by baseline, at a programmable sample rate and beat period.
- Also emits a reference beat strobe and beat counter, so a bench or on-chip self-test can check detected peaks against ground truth.

Parameters:
- DIV_W, 8, width of clock-per-sample divider input.
- PER_W, 8, width of beat-period input (in samples).
- MIN_PER, 9, minimum effective beat period in samples. Must be ≥ 9.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable. Low freezes generator state.
- div  input  DIV_W  clocks per sample minus 1. Used live.
- period  input  PER_W  samples per beat. Latched at each beat start.
- amp_hi  input  1  R-peak amplitude select: 1 gives 7, 0 gives 5. Latched at beat start.
- sample  output  3  current waveform sample, registered.
- sample_valid  output  1  one-cycle strobe when sample updates.
- beat  output  1  one-cycle strobe coincident with the R sample.
- beat_count  output  8  number of R samples emitted, modulo 256.

Behaviour:
- Reset (async, immediate):
  - sample=3'd1, sample_valid=0, beat=0, beat_count=0.
  - prescaler=0, idx=0, state=IDLE.
  - per_q=MIN_PER, amp_q=1.
- Prescaler:
  - Increments while en=1.
  - When prescaler==div and en=1: tick fires and prescaler clears to 0 on the same edge.
  - div=0 gives a tick every enabled clock.
  - div is compared live. If div is lowered below the current prescaler value, the prescaler continues to its wrap at all-ones, then resumes normally. No mid-count tick is generated.
- States:
  - IDLE: no sample_valid.
  - RUN.
- IDLE->RUN on the first tick. That tick is a beat start.
- Beat start (any tick with idx wrapping to 0, including the first):
  - per_q = max(period, MIN_PER).
  - amp_q = amp_hi.
- Sample index idx:
  - Advances 0..per_q-1 on each tick in RUN.
  - Wraps to 0 after per_q-1.
- Sample value by idx (registered on the tick edge):
  - idx 0-1 → P = 2.
  - idx 2 → Q = 0.
  - idx 3 → R = 7 if amp_q=1, else 5.
  - idx 4 → S = 0.
  - idx 5-7 → T = 3.
  - idx 8..per_q-1 → baseline 1.
- sample_valid:
  - Asserted for exactly the cycle after each tick edge.
  - Latency from first enabled edge = div+1 clocks.
- beat:
  - Asserted with sample_valid when the R sample is emitted.
  - beat_count increments on that same edge and wraps 255→0.
- en=0:
  - prescaler, idx, state, per_q, amp_q all hold.
  - sample holds its last value.
  - sample_valid=0, beat=0.
  - Re-enable resumes exactly where it stopped; no sample is repeated or skipped.
- Input changes:
  - period/amp_hi changes mid-beat take effect at the next beat start only.
  - period < MIN_PER (including 0) is clamped to MIN_PER.
- Reset asserted mid-beat:
  - All outputs return to reset values asynchronously.
  - After release, the next tick restarts at idx 0 (P) with fresh latch.
- sample_valid and beat are never asserted when no tick occurred.
- Widths: per_q and idx are PER_W bits. Comparisons are unsigned.

Test Plan:
- div=0, period=10, amp_hi=1, en=1 from reset release:
  - sample_valid high every clock.
  - sample sequence 2,2,0,7,0,3,3,3,1,1, repeating.
  - beat on 4th and 14th valids; beat_count=2 after 20 valids.
- div=3, period=12, amp_hi=0:
  - First sample_valid 4 clocks after en rises, then every 4 clocks.
  - R sample=5.
  - Baseline run of four 1s per beat.
- period=4 (and period=0):
  - Clamped to 9: sequence 2,2,0,7,0,3,3,3,1, repeating every 9 valids.
- Change period 10→20 and amp_hi 1→0 at idx 5:
  - Current beat completes with 10 samples and R=7.
  - Next beat has 20 samples and R=5.
- en dropped for 7 clocks after the 3rd valid (div=1):
  - No valids during the gap; sample holds 0.
  - After re-enable, the next valid is 7 (idx 3) exactly 2 clocks later.
- Assert reset mid-beat (idx 6), then run 256 beats at div=0, period=9:
  - Outputs reset immediately.
  - Restart at sample 2.
  - beat_count wraps to 0 after the 256th beat.
